fifo_order_arbiter: RTL
=======================

Name: fifo_order_arbiter

Overview:
- Parametrised first-come-first-served arbiter for N requesters; next generation of the 4-user queue arbiter.
- Detects new request rising edges and queues the requester index in arrival order.
- Grants one requester at a time (one-hot) and holds the grant until that requester releases its request.
- Sits between N bus masters and a shared resource; replaces fixed 4-user encodings with an index queue.

Parameters:
N, 4, number of requesters (2..16)
IDXW, $clog2(N), width of a requester index (derived; not to be overridden)
MAX_HOLD, 64, grant cycle limit; used only when ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  N  request level per requester; bit i = requester i
grant  output  N  one-hot grant, or all zero
grant_valid  output  1  high when grant is non-zero
grant_idx  output  IDXW  index of current owner; 0 when grant_valid is low
q_count  output  IDXW+1  number of queued (not yet granted) entries
timeout  output  1  one-cycle pulse on forced revoke (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous assert, synchronous release): grant=0, grant_valid=0, grant_idx=0, q_count=0, timeout=0, req_q=0, pending=0, state=IDLE, queue pointers 0.
- Edge detect: new[i] = req[i] & ~req_q[i] & ~pending[i]. req_q is req registered every cycle.
- Enqueue: on the clock edge where new[i]=1, write i at the tail and set pending[i]. Several new bits in one cycle are enqueued in ascending index order, so the lowest index lands nearest the head.
- Queue depth is N. pending[] holds at most one entry per requester, so overflow is impossible. Assert on overflow in simulation.
- pending[i] covers both "queued" and "owner". While pending is set, a re-raised edge is ignored.
- States: IDLE, GRANT.
- IDLE, q_count>0: pop the head index h.
  - req[h]=1: grant<=onehot(h), grant_idx<=h, state<=GRANT.
  - req[h]=0 (requester withdrew): skip. Clear pending[h], stay IDLE, no grant.
- IDLE, q_count==0: hold.
- GRANT: grant held while req[owner]=1. On the edge where req[owner]=0: grant<=0, pending[owner]<=0, state<=IDLE.
- The next grant can issue no earlier than the following edge, giving a mandatory one-cycle zero-grant gap between owners.
- Latency: req high before edge k with the queue empty and state IDLE → enqueued at edge k → grant visible after edge k+1.
- Enqueue and pop on the same edge: the pop uses pre-edge contents, and q_count reflects both changes.
- An empty-queue enqueue does not bypass to grant in the same cycle.
- Pointers wrap modulo N. q_count saturates by construction at N.
- A requester released mid-queue and re-raised before its pop is granted normally, because req is sampled at pop time.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on grant and increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 with req[owner] still high: grant<=0, pending[owner]<=0, state<=IDLE, timeout pulses 1 cycle.
  - The requester must drop and re-raise req to requeue.
- Undefined: no counter, timeout tied 0, grant held indefinitely.

Decomposition:
- Package arb_pkg: state enum (IDLE, GRANT) and onehot/index conversion functions.
- One sub-module, arb_idx_queue: N-deep index FIFO.
  - Multi-push per cycle: push mask, in ascending order.
  - Single pop.
  - Exposes head and count.

Test Plan:
- Reset mid-grant: owner 2 granted, rst_n low → grant=0 and q_count=0 immediately (asynchronous); all stay zero after release.
- req=4'b0001 at edge 0 → grant=4'b0001, grant_idx=0 after edge 1; drop req → grant=0 the next edge.
- req rises 3, then 1, then 0 on consecutive cycles, each held → grants issue in order 3,1,0, with one zero-grant cycle between owners.
- req=4'b1010 in the same cycle → grant 1 first, then 3.
- Requester 2 queued behind owner 0 drops req before its turn → skipped, no grant to 2, pending cleared; a later re-raise gets served.
- ARB_TIMEOUT_EN, MAX_HOLD=8, requester 1 holds req indefinitely → grant revoked after 8 grant cycles with a one-cycle timeout pulse; no re-grant until req toggles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the first-come-first-served arbiter.
// Holds the IDLE/GRANT state encoding and the one-hot/index helpers.
// Helpers are sized for the largest supported requester count (16).
package arb_pkg;

  // IDLE/GRANT state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Largest requester count the helpers cover
  localparam int MAX_REQ = 16;

  // Index to one-hot; callers truncate to their own requester count
  function automatic logic [MAX_REQ-1:0] idx2onehot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

  // One-hot to index; an all-zero vector maps to index 0
  function automatic logic [3:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_order_arbiter_if.sv
// Request/grant bundle between N bus masters and the arbiter.
// master: requester side (drives req); slave: arbiter side.
// Pure wiring, no storage.
interface fifo_order_arbiter_if #(parameter int N = 4);
  localparam int IDXW = $clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW:0]   q_count;
  logic            timeout;

  modport master (output req, input grant, grant_valid, grant_idx, q_count, timeout);
  modport slave  (input req, output grant, grant_valid, grant_idx, q_count, timeout);
endinterface

// File: rtl/arb_idx_queue.sv
// N-deep FIFO of requester indices; several pushes per cycle, one pop.
// Latency: pushed entries are visible at head/count after the edge.
// No backpressure: the caller guarantees at most N live entries.
module arb_idx_queue #(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           push_mask_i,
  input  logic                   pop_i,
  output logic [$clog2(N)-1:0]   head_o,
  output logic [$clog2(N):0]     count_o
);
  localparam int IDXW = $clog2(N);

  logic [IDXW-1:0] mem_q [N];
  logic [IDXW-1:0] mem_d [N];
  logic [IDXW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDXW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDXW:0]   count_q, count_d;
  logic [IDXW:0]   push_cnt;

  // Pointers wrap modulo N, which need not be a power of two
  function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] p);
    return (p == IDXW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  // Write set bits of the push mask at the tail, lowest index first
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    push_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (push_mask_i[i]) begin
        mem_d[wr_ptr_d] = IDXW'(i);
        wr_ptr_d        = next_ptr(wr_ptr_d);
        push_cnt        = push_cnt + 1'b1;
      end
    end
    rd_ptr_d = pop_i ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + push_cnt - {{IDXW{1'b0}}, pop_i};
  end

  // Queue state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Overflow and empty-pop must never happen given one entry per requester
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((int'(count_q) + int'(push_cnt) - int'(pop_i)) <= N);
      assert (!(pop_i && (count_q == '0)));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fifo_order_arbiter.sv
// First-come-first-served arbiter for N requesters; optional hold timeout via ARB_TIMEOUT_EN.
// Latency: req edge enqueued at edge k, grant visible after edge k+1; one idle cycle between owners.
// Backpressure: none; grant held until the owner drops req (or the hold limit expires).
module fifo_order_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_order_arbiter_if.slave  bus
);
  localparam int IDXW = $clog2(N);

  if ((N < 2) || (N > MAX_REQ) || (MAX_HOLD < 2)) begin : g_bad_cfg
    $error("fifo_order_arbiter: N must be 2..16 and MAX_HOLD at least 2");
  end

  logic [N-1:0]    req_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [0:0]      state_q, state_d;
  logic [N-1:0]    new_req;
  logic            pop;
  logic [IDXW-1:0] head;
  logic [IDXW-1:0] owner;
  logic [IDXW:0]   count;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLDW = $clog2(MAX_HOLD);
  logic [HOLDW-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;
`endif

  // A requester already queued or owning is ignored until it is retired
  assign new_req = bus.req & ~req_q & ~pending_q;
  assign owner   = IDXW'(onehot2idx(16'(grant_q)));
  assign pop     = (state_q == ST_IDLE) && (count != '0);

  arb_idx_queue #(.N(N)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_mask_i (new_req),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  // Grant FSM: pop the head in IDLE, hold the grant until the owner lets go
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pending_d = pending_q | new_req;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (bus.req[head]) begin
            grant_d = N'(idx2onehot(4'(head)));
            state_d = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
          end else begin
            // Requester withdrew while queued: retire it without a grant
            pending_d[head] = 1'b0;
          end
        end
      end
      ST_GRANT: begin
        if (!bus.req[owner]) begin
          grant_d          = '0;
          pending_d[owner] = 1'b0;
          state_d          = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLDW'(MAX_HOLD - 1)) begin
          // Forced revoke; the requester must toggle req to requeue
          grant_d          = '0;
          pending_d[owner] = 1'b0;
          state_d          = ST_IDLE;
          timeout_d        = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      state_q   <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      req_q     <= bus.req;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      state_q   <= state_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx   = owner;
  assign bus.q_count     = count;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule
